regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writers:
  - the in-order pipeline writeback stage (pipe);
  - a multi-cycle unit such as mul/div or load-miss (mc).
- Keeps a per-register busy scoreboard for in-flight mc destinations, so decode can stall on RAW hazards.
- Sits between the writeback stage, the multi-cycle unit and the register file's write_data/wren/write_reg inputs.

Parameters:
- NREGS, 32, number of architectural registers; register index width RW = $clog2(NREGS).
- XLEN, 32, data width.
- MAX_WAIT, 4, cycles an mc request may be refused before it is force-granted; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pipe_valid  in  1  pipeline writeback request
- pipe_rd  in  RW  pipeline destination register
- pipe_data  in  XLEN  pipeline write data
- pipe_stall  out  1  pipeline must hold its writeback this cycle (combinational)
- mc_valid  in  1  mc writeback request
- mc_rd  in  RW  mc destination register
- mc_data  in  XLEN  mc write data
- mc_ready  out  1  mc request accepted this cycle (combinational)
- mc_issue  in  1  decode dispatched an op to the mc unit
- mc_issue_rd  in  RW  destination register of the dispatched op
- busy  out  NREGS  scoreboard; busy[i]=1 means register i has a pending mc write
- rf_wren  out  1  register file write enable (registered)
- rf_write_reg  out  RW  register file write address (registered)
- rf_write_data  out  XLEN  register file write data (registered)

Behaviour:
- Reset (asynchronous, immediate): rf_wren=0, rf_write_reg=0, rf_write_data=0, busy=0, wait_cnt=0.
  - pipe_stall and mc_ready are combinational and reset-independent.
- Write latency:
  - A request accepted in cycle N produces rf_wren=1 with its rd/data in cycle N+1.
  - Exactly one write per cycle.
- x0 writes:
  - A request with rd==0 is accepted (pipe not stalled / mc_ready=1) but generates no rf_wren and does not occupy the port.
  - Therefore, if pipe_rd==0, a simultaneous mc request is granted in the same cycle.
- Arbitration, default: pipe has priority.
  - mc_ready = mc_valid & (~pipe_valid | pipe_rd==0 | force).
  - pipe_stall = pipe_valid & pipe_rd!=0 & force & mc_valid & mc_rd!=0.
- Starvation counter wait_cnt, width 4:
  - increments each cycle mc_valid=1 and mc_ready=0;
  - clears when mc_ready=1 or mc_valid=0;
  - saturates at MAX_WAIT.
  - force = (wait_cnt==MAX_WAIT).
- Handshake rules:
  - mc must hold valid, rd and data stable until mc_ready=1.
  - The pipeline must hold its writeback while pipe_stall=1.
- Scoreboard:
  - mc_issue with mc_issue_rd!=0 sets busy[mc_issue_rd] at the next edge.
  - An mc grant with mc_rd!=0 clears busy[mc_rd] at the next edge.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is constant 0.
  - mc_issue to an already-busy register is a protocol violation; flag it with an assertion only.
- Simultaneous events:
  - pipe and mc both writing the same rd in one cycle: pipe wins the port, mc waits, so the mc value lands later and is final.
  - Decode must prevent this case via busy; the arbiter does not reorder.
- Reset mid-operation: pending requests, counters and scoreboard are discarded; no write is issued after reset.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined: force logic as above; mc is guaranteed a grant within MAX_WAIT+1 cycles of asserting mc_valid.
- Undefined: wait_cnt is removed, force is held 0, pipe_stall is tied 0, and arbitration is strict pipe priority (mc may starve).

Decomposition:
- Package regfile_pkg:
  - XLEN, NREGS, RW constants;
  - reg_idx_t (logic [RW-1:0]);
  - wb_req_t struct {valid, rd, data}.
- One sub-module, wb_scoreboard: the busy vector with set/clear ports.
- Arbitration, counter and output register stay in the top module.

Test Plan:
- Reset while rf_wren=1 and busy=32'h0000_0024 -> all outputs 0 immediately.
- pipe_valid, rd=5, data=32'hDEAD_BEEF in cycle N -> rf_wren=1, rf_write_reg=5, rf_write_data=32'hDEAD_BEEF in N+1.
- pipe rd=7 and mc rd=9 both valid, pipe busy every cycle, WB_STARVE_GUARD_EN defined, MAX_WAIT=4:
  - mc_ready=0 for 4 cycles;
  - 5th cycle: mc_ready=1, pipe_stall=1;
  - next cycle: rf_write_reg=9.
- Same stimulus without the macro -> mc_ready stays 0 for 20 cycles and pipe_stall is never asserted.
- pipe rd=0 together with mc rd=3, data=32'h1234 -> mc_ready=1 the same cycle, pipe_stall=0, next cycle rf_write_reg=3, no write to x0.
- mc_issue rd=3 -> busy[3]=1 at the next edge; later, mc grant rd=3 in the same cycle as mc_issue rd=3 -> busy[3] stays 1 (set wins); mc_issue rd=0 -> busy[0] stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The arbiter top and its interface derive their default widths from here.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RW    = $clog2(NREGS);

  typedef logic [RW-1:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Writes to x0 are architecturally discarded and never reach the port.
  function automatic logic rd_nz(reg_idx_t rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the pipe/mc writeback handshakes, the scoreboard and the register-file write port.
// slave = arbiter side, master = the surrounding core (or a bench).
interface regfile_wb_arbiter_if #(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int XLEN  = regfile_pkg::XLEN
);
  localparam int RW = $clog2(NREGS);

  logic             pipe_valid;
  logic [RW-1:0]    pipe_rd;
  logic [XLEN-1:0]  pipe_data;
  logic             pipe_stall;

  logic             mc_valid;
  logic [RW-1:0]    mc_rd;
  logic [XLEN-1:0]  mc_data;
  logic             mc_ready;

  logic             mc_issue;
  logic [RW-1:0]    mc_issue_rd;
  logic [NREGS-1:0] busy;

  logic             rf_wren;
  logic [RW-1:0]    rf_write_reg;
  logic [XLEN-1:0]  rf_write_data;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  mc_valid, mc_rd, mc_data,
    input  mc_issue, mc_issue_rd,
    output pipe_stall, mc_ready, busy,
    output rf_wren, rf_write_reg, rf_write_data
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output mc_valid, mc_rd, mc_data,
    output mc_issue, mc_issue_rd,
    input  pipe_stall, mc_ready, busy,
    input  rf_wren, rf_write_reg, rf_write_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Per-register busy bits for in-flight multi-cycle destinations.
// A set and a clear of the same register in one cycle leave it busy; bit 0 never sets.
module wb_scoreboard #(
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     set_en,
  input  logic [$clog2(NREGS)-1:0] set_idx,
  input  logic                     clr_en,
  input  logic [$clog2(NREGS)-1:0] clr_idx,
  output logic [NREGS-1:0]         busy
);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  assign busy_d[0] = 1'b0;
  assign busy[0]   = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_bit
      logic hit_set;
      logic hit_clr;

      assign hit_set = set_en && (set_idx == ($clog2(NREGS))'(gi));
      assign hit_clr = clr_en && (clr_idx == ($clog2(NREGS))'(gi));

      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (hit_clr) busy_d[gi] = 1'b0;
        if (hit_set) busy_d[gi] = 1'b1;
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy_q[gi] <= 1'b0;
        else          busy_q[gi] <= busy_d[gi];
      end

      assign busy[gi] = busy_q[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q[0] <= 1'b0;
    else          busy_q[0] <= busy_d[0];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the pipeline writeback and a multi-cycle unit.
// Optional WB_STARVE_GUARD_EN: starvation counter force-grants mc after MAX_WAIT refused cycles.
module regfile_wb_arbiter #(
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int MAX_WAIT = 4
) (
  input logic                 clock,
  input logic                 reset_n,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_pkg::*;

  localparam int RW = $clog2(NREGS);

  wb_req_t pipe_req;
  wb_req_t mc_req;
  logic    force_grant;
  logic    pipe_stall;
  logic    mc_ready;
  logic    mc_write;
  logic    pipe_write;

  assign pipe_req = '{valid: bus.pipe_valid, rd: bus.pipe_rd, data: bus.pipe_data};
  assign mc_req   = '{valid: bus.mc_valid,   rd: bus.mc_rd,   data: bus.mc_data};

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_d;
  logic [3:0] wait_cnt_q;

  assign force_grant = (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!mc_req.valid || mc_ready)  wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end

  // Only a real pipe write collides with a real mc write; x0 on either side frees the port.
  assign pipe_stall = pipe_req.valid & rd_nz(pipe_req.rd) & force_grant
                    & mc_req.valid & rd_nz(mc_req.rd);
`else
  assign force_grant = 1'b0;
  assign pipe_stall  = 1'b0;
`endif

  assign mc_ready   = mc_req.valid & (~pipe_req.valid | ~rd_nz(pipe_req.rd) | force_grant);
  assign mc_write   = mc_ready & rd_nz(mc_req.rd);
  assign pipe_write = pipe_req.valid & ~pipe_stall & rd_nz(pipe_req.rd) & ~mc_write;

  logic            rf_wren_d;
  logic            rf_wren_q;
  logic [RW-1:0]   rf_write_reg_d;
  logic [RW-1:0]   rf_write_reg_q;
  logic [XLEN-1:0] rf_write_data_d;
  logic [XLEN-1:0] rf_write_data_q;

  // Address/data hold their last value on idle cycles to avoid needless toggling.
  always_comb begin
    rf_wren_d       = mc_write | pipe_write;
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    if (mc_write) begin
      rf_write_reg_d  = mc_req.rd;
      rf_write_data_d = mc_req.data;
    end else if (pipe_write) begin
      rf_write_reg_d  = pipe_req.rd;
      rf_write_data_d = pipe_req.data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wren_q       <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
    end else begin
      rf_wren_q       <= rf_wren_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  wb_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (bus.mc_issue & rd_nz(bus.mc_issue_rd)),
    .set_idx (bus.mc_issue_rd),
    .clr_en  (mc_write),
    .clr_idx (mc_req.rd),
    .busy    (bus.busy)
  );

  assign bus.pipe_stall    = pipe_stall;
  assign bus.mc_ready      = mc_ready;
  assign bus.rf_wren       = rf_wren_q;
  assign bus.rf_write_reg  = rf_write_reg_q;
  assign bus.rf_write_data = rf_write_data_q;

  a_max_wait_range: assert property (@(posedge clock) disable iff (!reset_n)
    (MAX_WAIT >= 1) && (MAX_WAIT <= 15));

  // Re-issuing to a register is legal only when its pending write retires this same cycle.
  a_issue_to_busy: assert property (@(posedge clock) disable iff (!reset_n)
    (bus.mc_issue && rd_nz(bus.mc_issue_rd)) |->
      (!bus.busy[bus.mc_issue_rd] || (mc_write && mc_req.rd == bus.mc_issue_rd)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; starvation expectations follow WB_STARVE_GUARD_EN.
module tb_regfile_wb_arbiter;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter_if #(.NREGS(32), .XLEN(32)) bus ();

  regfile_wb_arbiter #(.NREGS(32), .XLEN(32), .MAX_WAIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.mc_valid = 1'b0;   bus.mc_rd = '0;   bus.mc_data = '0;
    bus.mc_issue = 1'b0;   bus.mc_issue_rd = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #2;
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", bus.rf_wren); end
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 00000000", bus.busy); end
    checks++; if (bus.rf_write_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus.rf_write_data); end
    step(); step();
    reset_n = 1'b1;
    step();
    $display("test_reset: wren=%b busy=%h", bus.rf_wren, bus.busy);
  endtask

  task automatic test_pipe_write();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL pipe_stall_idle: got %b expected 0", bus.pipe_stall); end
    step();
    idle_inputs();
    checks++; if (bus.rf_wren !== 1'b1) begin errors++; $display("FAIL pipe_wren: got %b expected 1", bus.rf_wren); end
    checks++; if (bus.rf_write_reg !== 5'd5) begin errors++; $display("FAIL pipe_reg: got %0d expected 5", bus.rf_write_reg); end
    checks++; if (bus.rf_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_data: got %h expected deadbeef", bus.rf_write_data); end
    step();
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL pipe_wren_drop: got %b expected 0", bus.rf_wren); end
    $display("test_pipe_write: rd=5 data=deadbeef");
  endtask

  task automatic test_x0();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h5555_5555;
    bus.mc_valid = 1'b1;   bus.mc_rd = 5'd3;   bus.mc_data = 32'h0000_1234;
    #1;
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL x0_mc_ready: got %b expected 1", bus.mc_ready); end
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL x0_pipe_stall: got %b expected 0", bus.pipe_stall); end
    step();
    idle_inputs();
    checks++; if (bus.rf_wren !== 1'b1) begin errors++; $display("FAIL x0_mc_wren: got %b expected 1", bus.rf_wren); end
    checks++; if (bus.rf_write_reg !== 5'd3) begin errors++; $display("FAIL x0_mc_reg: got %0d expected 3", bus.rf_write_reg); end
    checks++; if (bus.rf_write_data !== 32'h0000_1234) begin errors++; $display("FAIL x0_mc_data: got %h expected 00001234", bus.rf_write_data); end
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'hAAAA_AAAA;
    step();
    idle_inputs();
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL x0_pipe_nowrite: got %b expected 0", bus.rf_wren); end
    $display("test_x0: pipe rd=0 with mc rd=3");
  endtask

  task automatic test_starve();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_data = 32'h7777_7777;
    bus.mc_valid = 1'b1;   bus.mc_rd = 5'd9;   bus.mc_data = 32'h9999_9999;
`ifdef WB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL starve_refused[%0d]: got %b expected 0", i, bus.mc_ready); end
      checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_nostall[%0d]: got %b expected 0", i, bus.pipe_stall); end
      step();
      checks++; if (bus.rf_write_reg !== 5'd7) begin errors++; $display("FAIL starve_pipe_reg[%0d]: got %0d expected 7", i, bus.rf_write_reg); end
    end
    #1;
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL starve_force_ready: got %b expected 1", bus.mc_ready); end
    checks++; if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_force_stall: got %b expected 1", bus.pipe_stall); end
    step();
    bus.mc_valid = 1'b0;
    checks++; if (bus.rf_write_reg !== 5'd9) begin errors++; $display("FAIL starve_mc_reg: got %0d expected 9", bus.rf_write_reg); end
    checks++; if (bus.rf_write_data !== 32'h9999_9999) begin errors++; $display("FAIL starve_mc_data: got %h expected 99999999", bus.rf_write_data); end
    #1;
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_unstall: got %b expected 0", bus.pipe_stall); end
    step();
    checks++; if (bus.rf_write_reg !== 5'd7) begin errors++; $display("FAIL starve_pipe_resume: got %0d expected 7", bus.rf_write_reg); end
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL strict_refused[%0d]: got %b expected 0", i, bus.mc_ready); end
      checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL strict_nostall[%0d]: got %b expected 0", i, bus.pipe_stall); end
      step();
      checks++; if (bus.rf_write_reg !== 5'd7) begin errors++; $display("FAIL strict_pipe_reg[%0d]: got %0d expected 7", i, bus.rf_write_reg); end
    end
    bus.pipe_valid = 1'b0;
    #1;
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL strict_mc_ready: got %b expected 1", bus.mc_ready); end
    step();
    bus.mc_valid = 1'b0;
    checks++; if (bus.rf_write_reg !== 5'd9) begin errors++; $display("FAIL strict_mc_reg: got %0d expected 9", bus.rf_write_reg); end
`endif
    idle_inputs();
    step();
    $display("test_starve: pipe rd=7 vs mc rd=9");
  endtask

  task automatic test_scoreboard();
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd3;
    #1;
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL sb_not_yet: got %h expected 00000000", bus.busy); end
    step();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0000_0008) begin errors++; $display("FAIL sb_set: got %h expected 00000008", bus.busy); end
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd3; bus.mc_data = 32'h0000_00AB;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd3;
    #1;
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL sb_grant_ready: got %b expected 1", bus.mc_ready); end
    step();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0000_0008) begin errors++; $display("FAIL sb_set_wins: got %h expected 00000008", bus.busy); end
    checks++; if (bus.rf_write_reg !== 5'd3) begin errors++; $display("FAIL sb_grant_reg: got %0d expected 3", bus.rf_write_reg); end
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd3; bus.mc_data = 32'h0000_00CD;
    step();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h expected 00000000", bus.busy); end
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd0;
    step();
    idle_inputs();
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL sb_x0: got %h expected 00000000", bus.busy); end
    $display("test_scoreboard: set/clear/x0 on rd=3 and rd=0");
  endtask

  task automatic test_reset_mid();
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd2;
    step();
    bus.mc_issue_rd = 5'd5;
    step();
    bus.mc_issue = 1'b0;
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd6; bus.pipe_data = 32'h0000_0066;
    step();
    checks++; if (bus.busy !== 32'h0000_0024) begin errors++; $display("FAIL mid_busy_pre: got %h expected 00000024", bus.busy); end
    checks++; if (bus.rf_wren !== 1'b1) begin errors++; $display("FAIL mid_wren_pre: got %b expected 1", bus.rf_wren); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL mid_wren: got %b expected 0", bus.rf_wren); end
    checks++; if (bus.rf_write_reg !== 5'd0) begin errors++; $display("FAIL mid_reg: got %0d expected 0", bus.rf_write_reg); end
    checks++; if (bus.rf_write_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h expected 00000000", bus.rf_write_data); end
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL mid_busy: got %h expected 00000000", bus.busy); end
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd4; bus.mc_data = 32'h0000_0044;
    step();
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL mid_hold_wren: got %b expected 0", bus.rf_wren); end
    idle_inputs();
    reset_n = 1'b1;
    step();
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL mid_after_wren: got %b expected 0", bus.rf_wren); end
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL mid_after_busy: got %h expected 00000000", bus.busy); end
    $display("test_reset_mid: reset with busy=00000024 and write in flight");
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_x0();
    test_starve();
    test_scoreboard();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
